// File: rtl/uart_wake_detector.sv
// UART RX wake detector: synchronises and glitch-filters the RX pin, arms after an
// idle line, qualifies a minimum-length start bit and issues a one-cycle wake pulse.
module uart_wake_detector #(
    parameter int SYNC_STAGES    = 2,
    parameter int GLITCH_CYCLES  = 4,
    parameter int IDLE_CYCLES    = 16,
    parameter int MIN_LOW_CYCLES = 8,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx_async,
    input  logic       cnt_clr,
    output logic       wake_pulse,
    output logic       armed,
    output logic [7:0] wake_count
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_LISTEN   = 3'd2,
        ST_MEASURE  = 3'd3,
        ST_WAKE     = 3'd4,
        ST_HOLDOFF  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LOW     = CNT_W'(MIN_LOW_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : (val + 8'd1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_sync_s;
    logic                   rx_filt_r;
    logic [CNT_W-1:0]       glitch_cnt_r;

    state_t                 state_r;
    state_t                 fsm_state_s;
    state_t                 next_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       fsm_cnt_s;
    logic [CNT_W-1:0]       cnt_next_s;

    logic                   wake_pulse_r;
    logic                   armed_r;
    logic [7:0]             wake_count_r;
    logic                   wake_next_s;
    logic [7:0]             wake_count_next_s;

    assign rx_sync_s = sync_r[SYNC_STAGES-1];

    // RX synchroniser chain, resets to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_async};
        end
    end

    // Glitch filter: rx_filt follows rx_sync only after a sustained disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_filt_r    <= 1'b1;
            glitch_cnt_r <= CNT_ZERO;
        end else if (rx_sync_s != rx_filt_r) begin
            if (glitch_cnt_r == GLITCH_LAST) begin
                rx_filt_r    <= rx_sync_s;
                glitch_cnt_r <= CNT_ZERO;
            end else begin
                glitch_cnt_r <= glitch_cnt_r + CNT_ONE;
            end
        end else begin
            glitch_cnt_r <= CNT_ZERO;
        end
    end

    // Next-state and phase-counter logic; one counter serves idle, low and holdoff timing
    always_comb begin
        fsm_state_s = state_r;
        fsm_cnt_s   = cnt_r;
        case (state_r)
            ST_DISABLED: begin
                if (enable) begin
                    fsm_state_s = ST_ARMING;
                    fsm_cnt_s   = CNT_ZERO;
                end else begin
                    fsm_cnt_s   = CNT_ZERO;
                end
            end
            ST_ARMING: begin
                if (!rx_filt_r) begin
                    fsm_cnt_s   = CNT_ZERO;
                end else if (cnt_r == IDLE_LAST) begin
                    fsm_state_s = ST_LISTEN;
                    fsm_cnt_s   = CNT_ZERO;
                end else begin
                    fsm_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_LISTEN: begin
                if (!rx_filt_r) begin
                    fsm_state_s = ST_MEASURE;
                    fsm_cnt_s   = CNT_ONE;
                end else begin
                    fsm_cnt_s   = CNT_ZERO;
                end
            end
            ST_MEASURE: begin
                // A fully qualified low time wins over a same-cycle release
                if (cnt_r >= MIN_LOW) begin
                    fsm_state_s = ST_WAKE;
                    fsm_cnt_s   = CNT_ZERO;
                end else if (rx_filt_r) begin
                    fsm_state_s = ST_LISTEN;
                    fsm_cnt_s   = CNT_ZERO;
                end else begin
                    fsm_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_WAKE: begin
                fsm_state_s = ST_HOLDOFF;
                fsm_cnt_s   = CNT_ZERO;
            end
            ST_HOLDOFF: begin
                if (cnt_r == HOLD_LAST) begin
                    fsm_state_s = ST_ARMING;
                    fsm_cnt_s   = CNT_ZERO;
                end else begin
                    fsm_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                fsm_state_s = ST_DISABLED;
                fsm_cnt_s   = CNT_ZERO;
            end
        endcase
        next_state_s = enable ? fsm_state_s : ST_DISABLED;
        cnt_next_s   = enable ? fsm_cnt_s : CNT_ZERO;
    end

    // Wake counter next value: clear takes effect, but a coincident wake still counts
    always_comb begin
        wake_next_s = (next_state_s == ST_WAKE);
        if (cnt_clr) begin
            wake_count_next_s = wake_next_s ? 8'd1 : 8'd0;
        end else if (wake_next_s) begin
            wake_count_next_s = sat_inc8(wake_count_r);
        end else begin
            wake_count_next_s = wake_count_r;
        end
    end

    // State, counter and registered Moore outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_DISABLED;
            cnt_r        <= CNT_ZERO;
            wake_pulse_r <= 1'b0;
            armed_r      <= 1'b0;
            wake_count_r <= 8'd0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_next_s;
            wake_pulse_r <= wake_next_s;
            armed_r      <= (next_state_s == ST_LISTEN) || (next_state_s == ST_MEASURE);
            wake_count_r <= wake_count_next_s;
        end
    end

    assign wake_pulse = wake_pulse_r;
    assign armed      = armed_r;
    assign wake_count = wake_count_r;

endmodule

// File: tb/tb_uart_wake_detector.sv
// Directed self-checking bench for uart_wake_detector with default parameters.
module tb_uart_wake_detector;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rx_async;
    logic       cnt_clr;
    logic       wake_pulse;
    logic       armed;
    logic [7:0] wake_count;

    int n_tests;
    int n_fail;

    uart_wake_detector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx_async   (rx_async),
        .cnt_clr    (cnt_clr),
        .wake_pulse (wake_pulse),
        .armed      (armed),
        .wake_count (wake_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step n edges; edge index k is the k-th edge after the call
    task automatic window(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int k = 0; k < n; k++) begin
            step();
            if (wake_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    int p;
    int f;
    int total;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_async = 1'b1;
        cnt_clr  = 1'b0;
        run(3);
        check("rst_pulse", wake_pulse, 0);
        check("rst_armed", armed, 0);
        check("rst_count", wake_count, 0);
        rst_n = 1'b1;
        step();

        // T1: arm then a long low; pulse after edge 14
        enable = 1'b1;
        run(10);
        check("t1_arming_not_armed", armed, 0);
        run(10);
        check("t1_armed", armed, 1);
        rx_async = 1'b0;
        window(30, p, f);
        check("t1_pulses", p, 1);
        check("t1_latency", f, 14);
        check("t1_count", wake_count, 1);
        check("t1_armed_after", armed, 0);
        rx_async = 1'b1;
        run(90);
        check("t1_rearmed", armed, 1);

        // T2: 3-cycle glitch never reaches rx_filt
        rx_async = 1'b0;
        window(3, p, f);
        total = p;
        rx_async = 1'b1;
        window(20, p, f);
        check("t2_pulses", total + p, 0);
        check("t2_armed", armed, 1);

        // T3: lows of 6 and 7 cycles are rejected
        for (int n = 6; n <= 7; n++) begin
            rx_async = 1'b0;
            window(n, p, f);
            total = p;
            rx_async = 1'b1;
            window(20, p, f);
            check("t3_pulses", total + p, 0);
            check("t3_armed", armed, 1);
        end
        check("t3_count", wake_count, 1);

        // T4: disable with low_cnt = 7
        rx_async = 1'b0;
        run(13);
        check("t4_armed_measure", armed, 1);
        enable = 1'b0;
        step();
        check("t4_armed_off", armed, 0);
        check("t4_pulse_off", wake_pulse, 0);
        window(20, p, f);
        check("t4_pulses", p, 0);
        check("t4_count", wake_count, 1);

        // T5: line low through holdoff gives no second pulse until it re-idles
        enable   = 1'b1;
        rx_async = 1'b1;
        run(30);
        check("t5_armed", armed, 1);
        rx_async = 1'b0;
        window(30, p, f);
        check("t5_first_pulses", p, 1);
        check("t5_first_latency", f, 14);
        window(100, p, f);
        check("t5_holdoff_pulses", p, 0);
        check("t5_holdoff_armed", armed, 0);
        rx_async = 1'b1;
        run(30);
        rx_async = 1'b0;
        window(30, p, f);
        check("t5_second_pulses", p, 1);
        check("t5_count", wake_count, 3);

        // T6: async reset mid-MEASURE
        rx_async = 1'b1;
        run(90);
        rx_async = 1'b0;
        run(10);
        check("t6_armed_measure", armed, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_armed", armed, 0);
        check("t6_rst_pulse", wake_pulse, 0);
        check("t6_rst_count", wake_count, 0);
        rx_async = 1'b1;
        run(2);
        rst_n = 1'b1;

        // T6: 256 wakes saturate the count at 255
        total = 0;
        for (int i = 0; i < 256; i++) begin
            rx_async = 1'b1;
            run(90);
            rx_async = 1'b0;
            window(15, p, f);
            total += p;
            if (i == 254) check("t6_count_255th", wake_count, 255);
        end
        check("t6_total_pulses", total, 256);
        check("t6_count_sat", wake_count, 255);

        // T6: clear coincident with a wake leaves 1
        rx_async = 1'b1;
        run(90);
        rx_async = 1'b0;
        run(14);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("t6_clr_wake_pulse", wake_pulse, 1);
        check("t6_clr_wake_count", wake_count, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("t6_clr_only", wake_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
